// File: rtl/matrix_skew_aligner.sv
// Per-lane programmable delay that turns aligned rows into a systolic wavefront (skew)
// or a wavefront back into rows (deskew), draining fully before the mode switches.
module matrix_skew_aligner #(
  parameter int data_size = 4,
  parameter int size      = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mode,
  input  logic                      in_valid,
  input  logic [data_size*size-1:0] input_stream,
  output logic                      in_ready,
  output logic [data_size*size-1:0] output_stream,
  output logic [size-1:0]           out_lane_valid,
  output logic                      out_valid,
  output logic                      cur_mode,
  output logic                      busy
);

  localparam int depth = size - 1;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    SWITCH = 2'b10
  } state_t;

  state_t          state, state_nx;
  logic            accept;
  logic [size-1:0] lane_busy;

  assign accept = in_valid && in_ready;

  for (genvar c = 0; c < size; c++) begin : g_lane
    logic [data_size-1:0] in_data;
    logic [data_size-1:0] line_data_p0 [depth];
    logic [depth-1:0]     line_vld_p0;
    logic [data_size-1:0] dsk_data, skw_data, tap_data;
    logic                 dsk_vld, skw_vld, tap_vld;
    logic [data_size-1:0] out_data_p1;
    logic                 out_vld_p1;

    assign in_data = accept ? input_stream[(size-c)*data_size-1 -: data_size] : '0;

    // Tap for deskew: delay size-1-c stages; the last lane bypasses the line.
    if (size - 1 - c == 0) begin : g_dsk_direct
      assign dsk_data = in_data;
      assign dsk_vld  = accept;
    end else begin : g_dsk_tap
      assign dsk_data = line_data_p0[size-2-c];
      assign dsk_vld  = line_vld_p0[size-2-c];
    end

    // Tap for skew: delay c stages; lane 0 bypasses the line.
    if (c == 0) begin : g_skw_direct
      assign skw_data = in_data;
      assign skw_vld  = accept;
    end else begin : g_skw_tap
      assign skw_data = line_data_p0[c-1];
      assign skw_vld  = line_vld_p0[c-1];
    end

    assign tap_data = cur_mode ? skw_data : dsk_data;
    assign tap_vld  = cur_mode ? skw_vld : dsk_vld;

    // Stage p0: shift line; stage p1: output register.
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int k = 0; k < depth; k++) line_data_p0[k] <= '0;
        line_vld_p0 <= '0;
        out_data_p1 <= '0;
        out_vld_p1  <= 1'b0;
      end else begin
        line_data_p0[0] <= in_data;
        line_vld_p0[0]  <= accept;
        for (int k = 1; k < depth; k++) begin
          line_data_p0[k] <= line_data_p0[k-1];
          line_vld_p0[k]  <= line_vld_p0[k-1];
        end
        out_data_p1 <= tap_data;
        out_vld_p1  <= tap_vld;
      end
    end

    assign output_stream[(size-c)*data_size-1 -: data_size] = out_vld_p1 ? out_data_p1 : '0;
    assign out_lane_valid[c] = out_vld_p1;
    assign lane_busy[c]      = out_vld_p1 | (|line_vld_p0);
  end

  assign busy      = |lane_busy;
  assign out_valid = cur_mode ? (|out_lane_valid) : (&out_lane_valid);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      cur_mode <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == SWITCH) cur_mode <= mode;
    end
  end

  // A mode request blocks input the same cycle it appears.
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    case (state)
      RUN: begin
        in_ready = (mode == cur_mode);
        if (mode != cur_mode) state_nx = DRAIN;
      end
      DRAIN:   if (!busy) state_nx = SWITCH;
      SWITCH:  state_nx = RUN;
      default: state_nx = RUN;
    endcase
  end

endmodule

// File: doc/matrix_skew_aligner.md
# matrix_skew_aligner

Parametrised, runtime-switchable lane skew/deskew stage for the systolic matrix datapath. Each of `size` lanes of a `data_size*size` vector stream is delayed independently: skew mode staggers aligned rows into the diagonal wavefront a systolic array consumes, and deskew mode realigns a diagonal wavefront back into whole rows. It carries per-lane valids and drains safely before any mode change. It sits between the matrix memories and the multiply array on the input side, and after the array on the output side.

## Interface
- `data_size`, 4, bits per matrix element
- `size`, 3, lane count (matrix dimension), ≥ 2
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `mode`  in  1  requested mode: 0 = deskew, 1 = skew
- `in_valid`  in  1  `input_stream` holds a vector this cycle
- `input_stream`  in  `data_size*size`  lane c at bits `[(size-c)*data_size-1 -: data_size]` (lane 0 at MSB)
- `in_ready`  out  1  block accepts input this cycle
- `output_stream`  out  `data_size*size`  same lane packing; a lane reads 0 when its lane valid is 0
- `out_lane_valid`  out  `size`  bit c = lane c output valid
- `out_valid`  out  1  deskew: AND of `out_lane_valid`; skew: OR of `out_lane_valid`
- `cur_mode`  out  1  mode currently applied
- `busy`  out  1  any delay stage or output register holds a valid

## Operation
- Each lane has a `size-1`-deep shift line of {data, valid} plus one output register. The tap is selected by `cur_mode`.
- Lane delays: in deskew, lane c is delayed `size-1-c` stages; in skew, lane c is delayed `c` stages. The output register adds 1 cycle.
- A vector is accepted when `in_valid && in_ready`. Every lane entry takes the valid bit of that acceptance. Non-accepted cycles shift in zero data with valid 0.
- The pipeline always advances; there is no output backpressure.
- State machine, 2-bit encoding:
  - RUN: `in_ready` = 1. If `mode != cur_mode`, go to DRAIN. The change is detected on the same cycle it appears, and input on that cycle is not accepted.
  - DRAIN: `in_ready` = 0, shifting continues. When `busy` = 0, go to SWITCH.
  - SWITCH: `in_ready` = 0. Load `cur_mode <= mode`, then go to RUN.
- If `mode` toggles back during DRAIN, the block still drains fully, and SWITCH loads the then-current `mode`.
- Reset result: state RUN, `cur_mode` = 0, all data and valids 0.
  - Outputs after reset: `output_stream` = 0, `out_lane_valid` = 0, `out_valid` = 0, `busy` = 0, `in_ready` = 1.
  - Reset mid-stream discards all in-flight data on the next edge.
- Data passes through unmodified. There is no arithmetic and no width change.

## Timing
- Latency, lane c: deskew `size-c` cycles; skew `c+1` cycles.
- Deskew, skewed input over `2*size-1` consecutive accepted rounds (lane c of row r entered at round r+c, padding zeros elsewhere):
  - Row r emerges whole at cycle r+size.
  - `out_valid` is high for exactly `size` consecutive cycles.
- Skew, `size` aligned rows on consecutive cycles:
  - Lane c of row r emerges at cycle r+c+1.
  - `out_valid` is high for `2*size-1` cycles.
- Mode change from a full pipeline:
  - DRAIN lasts until the last valid leaves the output register, at most `size` cycles.
  - Then 1 SWITCH cycle, and `in_ready` returns the following cycle.
- Mode change when empty: detect cycle, 1 cycle DRAIN with `busy` = 0, then SWITCH. `in_ready` is low for 3 cycles.

## Test plan
- Reset: hold `reset` for 2 cycles with `in_valid` = 1 and data 0xFFF → all outputs 0, `in_ready` = 1, `cur_mode` = 0.
- Deskew, `size` = 3, `data_size` = 4:
  - Stimulus: feed rounds {1,0,0}, {4,2,0}, {7,5,3}, {0,8,6}, {0,0,9} (lane 0 first).
  - Required: `output_stream` = 0x123, then 0x456, then 0x789, on cycles 3, 4, 5 with `out_valid` = 1; `out_valid` = 0 otherwise.
- Skew: `mode` = 1 (wait for `cur_mode` = 1), feed 0x123, 0x456, 0x789 → lanes emerge staggered as the deskew input above, `out_valid` high for 5 cycles.
- Mode change mid-stream: toggle `mode` one cycle after the 2nd accepted row → `in_ready` drops, both rows complete unchanged, `busy` falls, SWITCH occurs, and `cur_mode` flips before `in_ready` rises.
- Gaps: deskew with `in_valid` low on round 2 → the affected lanes read 0 with lane valid 0, and `out_valid` drops only on the cycles whose row is incomplete.
- Reset mid-stream: assert `reset` for 1 cycle while `busy` = 1 → `busy` = 0 and `output_stream` = 0 the next cycle, and no stale data appears afterward.
